// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated responder for the processor data port, backing a RAM and board I/O
module data_mem_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_WORDS = 4096
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] DataAddr,
  input  logic [15:0] DataOut,
  input  logic        WriteData,
  input  logic        ReadData,
  output logic [15:0] DataIn,
  output logic        DataWaitreq,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);
  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam int AW = $clog2(RAM_WORDS);
  // stall cycles remaining after the first request cycle (reads stall one more than writes)
  localparam logic [CW-1:0] RD_LOAD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] WR_LOAD = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  localparam logic WR_FAST = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, load;
  logic req, stall, rd_latch, wr_commit;
  logic sel_ram, sel_led, sel_hex, sel_sw, sel_key;
  logic [15:0] rd_val;
  logic [15:0] mem [RAM_WORDS];
  logic [6:0] hex [6];
  logic [9:0] sw_m, sw_s;
  logic [3:0] key_m, key_s;

  assign req = ReadData | WriteData;
  assign load = WriteData ? WR_LOAD : RD_LOAD;

  assign sel_ram = DataAddr[15:12] == 4'h0;
  assign sel_led = DataAddr == 16'h1000;
  assign sel_hex = (DataAddr[15:3] == 13'h0400) && (DataAddr[2:0] < 3'd6);
  assign sel_sw  = DataAddr == 16'h3000;
  assign sel_key = DataAddr == 16'h4000;

  assign rd_val = sel_ram ? mem[DataAddr[AW-1:0]] :
                  sel_led ? {6'b0, LEDR} :
                  sel_hex ? {9'b0, hex[DataAddr[2:0]]} :
                  sel_sw  ? {6'b0, sw_s} :
                  sel_key ? {12'b0, key_s} : 16'h0000;

  // stall is suppressed while reset is held so the processor never sees a phantom wait
  assign DataWaitreq = stall & Resetn;

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];

  // next state, wait counter, stall and the read-latch / write-commit strobes
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    stall = 1'b0;
    rd_latch = 1'b0;
    wr_commit = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && WriteData && WR_FAST) begin
          wr_commit = 1'b1;
        end else if (req) begin
          stall = 1'b1;
          cnt_n = load;
          state_n = (load == '0) ? S_DONE : S_WAIT;
          rd_latch = !WriteData && (load == '0);
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_n = S_IDLE;
          cnt_n = '0;
        end else if (cnt == CW'(1)) begin
          stall = 1'b1;
          state_n = S_DONE;
          cnt_n = '0;
          rd_latch = !WriteData;
        end else begin
          stall = 1'b1;
          cnt_n = cnt - CW'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        wr_commit = WriteData;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end

  // read data register, loaded on the last stall edge of a read
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) DataIn <= 16'h0000;
    else if (rd_latch) DataIn <= rd_val;
  end

  // LED and seven-segment registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      LEDR <= '0;
      for (int i = 0; i < 6; i++) hex[i] <= 7'h7F;
    end else if (wr_commit) begin
      if (sel_led) LEDR <= DataOut[9:0];
      for (int i = 0; i < 6; i++) if (sel_hex && DataAddr[2:0] == 3'(i)) hex[i] <= DataOut[6:0];
    end
  end

  // two-flop synchronizers for the asynchronous switch and key pins
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sw_m <= '0;
      sw_s <= '0;
      key_m <= '0;
      key_s <= '0;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
      key_m <= KEY;
      key_s <= key_m;
    end
  end

  // RAM write port; contents survive reset but a write in flight is dropped
  always_ff @(posedge Clock) begin
    if (Resetn && wr_commit && sel_ram) mem[DataAddr[AW-1:0]] <= DataOut;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks on three responders with 1, 0 and 3 wait states
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rd [3];
  logic wr [3];
  logic [15:0] addr [3];
  logic [15:0] dout [3];
  logic [15:0] din [3];
  logic wreq [3];
  logic [9:0] sw;
  logic [3:0] key;
  logic [9:0] ledr [3];
  logic [6:0] hx [3][6];
  int checks = 0;
  int errors = 0;
  int s;
  logic [15:0] q;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3)), .RAM_WORDS(4096)) u_dut (
      .Clock(clk), .Resetn(rst_n), .DataAddr(addr[g]), .DataOut(dout[g]),
      .WriteData(wr[g]), .ReadData(rd[g]), .DataIn(din[g]), .DataWaitreq(wreq[g]),
      .SW(sw), .KEY(key), .LEDR(ledr[g]),
      .HEX0(hx[g][0]), .HEX1(hx[g][1]), .HEX2(hx[g][2]),
      .HEX3(hx[g][3]), .HEX4(hx[g][4]), .HEX5(hx[g][5])
    );
  end

  // one complete transaction on responder k: counts stall cycles, captures DataIn in the completion cycle
  task automatic xfer(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                      output int stalls, output logic [15:0] rq);
    @(negedge clk);
    addr[k] = a;
    dout[k] = d;
    wr[k] = w;
    rd[k] = !w;
    #1;
    stalls = 0;
    while (wreq[k] && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    rq = din[k];
    @(posedge clk);
    #1;
    wr[k] = 1'b0;
    rd[k] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw = '0;
    key = '0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0;
      wr[k] = 1'b0;
      addr[k] = '0;
      dout[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (wreq[0] !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %b want 0", wreq[0]); end
    checks++; if (din[0] !== 16'h0000) begin errors++; $display("FAIL reset_datain got %h want 0000", din[0]); end
    rst_n = 1'b1;
    #1;
    checks++; if (ledr[0] !== 10'h000) begin errors++; $display("FAIL reset_ledr got %h want 000", ledr[0]); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (hx[0][i] !== 7'h7F) begin errors++; $display("FAIL reset_hex%0d got %h want 7f", i, hx[0][i]); end
    end
  endtask

  task automatic test_ram_rw;
    xfer(0, 1'b1, 16'h0010, 16'hBEEF, s, q);
    checks++; if (s !== 1) begin errors++; $display("FAIL ram_write_stall got %0d want 1", s); end
    xfer(0, 1'b0, 16'h0010, 16'h0000, s, q);
    checks++; if (s !== 2) begin errors++; $display("FAIL ram_read_stall got %0d want 2", s); end
    checks++; if (q !== 16'hBEEF) begin errors++; $display("FAIL ram_read_data got %h want beef", q); end
  endtask

  task automatic test_io;
    xfer(0, 1'b1, 16'h1000, 16'h03FF, s, q);
    checks++; if (ledr[0] !== 10'h3FF) begin errors++; $display("FAIL ledr_write got %h want 3ff", ledr[0]); end
    xfer(0, 1'b1, 16'h2003, 16'h0040, s, q);
    checks++; if (hx[0][3] !== 7'h40) begin errors++; $display("FAIL hex3_write got %h want 40", hx[0][3]); end
    checks++; if (hx[0][2] !== 7'h7F) begin errors++; $display("FAIL hex2_untouched got %h want 7f", hx[0][2]); end
    xfer(0, 1'b0, 16'h1000, 16'h0000, s, q);
    checks++; if (q !== 16'h03FF) begin errors++; $display("FAIL ledr_read got %h want 03ff", q); end
    xfer(0, 1'b0, 16'h2003, 16'h0000, s, q);
    checks++; if (q !== 16'h0040) begin errors++; $display("FAIL hex3_read got %h want 0040", q); end
  endtask

  task automatic test_sync_inputs;
    sw = 10'h2A5;
    key = 4'hA;
    repeat (3) @(posedge clk);
    xfer(0, 1'b0, 16'h3000, 16'h0000, s, q);
    checks++; if (q !== 16'h02A5) begin errors++; $display("FAIL sw_read got %h want 02a5", q); end
    xfer(0, 1'b0, 16'h4000, 16'h0000, s, q);
    checks++; if (q !== 16'h000A) begin errors++; $display("FAIL key_read got %h want 000a", q); end
  endtask

  task automatic test_unmapped;
    xfer(0, 1'b1, 16'h0123, 16'h0ABC, s, q);
    xfer(0, 1'b0, 16'h7123, 16'h0000, s, q);
    checks++; if (s !== 2) begin errors++; $display("FAIL unmapped_read_stall got %0d want 2", s); end
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %h want 0000", q); end
    xfer(0, 1'b1, 16'h7123, 16'hFFFF, s, q);
    checks++; if (s !== 1) begin errors++; $display("FAIL unmapped_write_stall got %0d want 1", s); end
    checks++; if (ledr[0] !== 10'h3FF) begin errors++; $display("FAIL unmapped_ledr got %h want 3ff", ledr[0]); end
    checks++; if (hx[0][3] !== 7'h40) begin errors++; $display("FAIL unmapped_hex3 got %h want 40", hx[0][3]); end
    xfer(0, 1'b0, 16'h0123, 16'h0000, s, q);
    checks++; if (q !== 16'h0ABC) begin errors++; $display("FAIL unmapped_ram_alias got %h want 0abc", q); end
    xfer(0, 1'b1, 16'h2006, 16'h0011, s, q);
    xfer(0, 1'b0, 16'h2006, 16'h0000, s, q);
    checks++; if (q !== 16'h0000) begin errors++; $display("FAIL hex6_read got %h want 0000", q); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    addr[1] = 16'h0001;
    dout[1] = 16'h1111;
    wr[1] = 1'b1;
    rd[1] = 1'b0;
    #1;
    checks++; if (wreq[1] !== 1'b0) begin errors++; $display("FAIL b2b_write1_stall got %b want 0", wreq[1]); end
    @(negedge clk);
    addr[1] = 16'h0002;
    dout[1] = 16'h2222;
    #1;
    checks++; if (wreq[1] !== 1'b0) begin errors++; $display("FAIL b2b_write2_stall got %b want 0", wreq[1]); end
    @(negedge clk);
    wr[1] = 1'b0;
    rd[1] = 1'b1;
    #1;
    checks++; if (wreq[1] !== 1'b1) begin errors++; $display("FAIL b2b_read_stall got %b want 1", wreq[1]); end
    @(negedge clk);
    #1;
    checks++; if (wreq[1] !== 1'b0) begin errors++; $display("FAIL b2b_read_done got %b want 0", wreq[1]); end
    checks++; if (din[1] !== 16'h2222) begin errors++; $display("FAIL b2b_read_data got %h want 2222", din[1]); end
    @(posedge clk);
    #1;
    rd[1] = 1'b0;
    xfer(1, 1'b0, 16'h0001, 16'h0000, s, q);
    checks++; if (s !== 1) begin errors++; $display("FAIL w0_read_stall got %0d want 1", s); end
    checks++; if (q !== 16'h1111) begin errors++; $display("FAIL b2b_first_write got %h want 1111", q); end
  endtask

  task automatic test_long_wait;
    xfer(2, 1'b1, 16'h0030, 16'hCAFE, s, q);
    checks++; if (s !== 3) begin errors++; $display("FAIL w3_write_stall got %0d want 3", s); end
    xfer(2, 1'b0, 16'h0030, 16'h0000, s, q);
    checks++; if (s !== 4) begin errors++; $display("FAIL w3_read_stall got %0d want 4", s); end
    checks++; if (q !== 16'hCAFE) begin errors++; $display("FAIL w3_read_data got %h want cafe", q); end
  endtask

  task automatic test_reset_abort;
    xfer(2, 1'b1, 16'h0020, 16'h1234, s, q);
    @(negedge clk);
    addr[2] = 16'h0020;
    dout[2] = 16'h5555;
    wr[2] = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (wreq[2] !== 1'b1) begin errors++; $display("FAIL abort_in_wait got %b want 1", wreq[2]); end
    rst_n = 1'b0;
    #1;
    checks++; if (wreq[2] !== 1'b0) begin errors++; $display("FAIL abort_waitreq got %b want 0", wreq[2]); end
    checks++; if (ledr[0] !== 10'h000) begin errors++; $display("FAIL abort_ledr got %h want 000", ledr[0]); end
    checks++; if (hx[0][3] !== 7'h7F) begin errors++; $display("FAIL abort_hex3 got %h want 7f", hx[0][3]); end
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 1'b0, 16'h0020, 16'h0000, s, q);
    checks++; if (q !== 16'h1234) begin errors++; $display("FAIL abort_ram_kept got %h want 1234", q); end
  endtask

  initial begin
    test_reset;
    test_ram_rw;
    test_io;
    test_sync_inputs;
    test_unmapped;
    test_back_to_back;
    test_long_wait;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
